c880_bist_ctrl: RTL and testbench



---
 rtl/c880_bist_pkg.sv | 17 +
 rtl/c880_misr.sv | 27 ++
 rtl/c880_bist_ctrl.sv | 82 ++++++++
 tb/tb_c880_bist_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/c880_bist_pkg.sv
// Shared widths, polynomial tap masks and FSM states for the c880 BIST controller.
package c880_bist_pkg;

   localparam int PI_W = 60;
   localparam int PO_W = 26;

   // Feedback masks: a set bit means that register bit feeds the XOR into bit 0.
   localparam logic [PI_W-1:0] LFSR_TAPS = 60'hC00_0000_0000_0000;  // x^60+x^59+1
   localparam logic [PO_W-1:0] MISR_TAPS = 26'h200_0023;             // x^26+x^6+x^2+x+1

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_t;

endpackage

// File: rtl/c880_misr.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in the response word.
module c880_misr #(
   parameter int          W    = 26,
   parameter logic [W-1:0] TAPS = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] resp_in,
   output logic [W-1:0] sig,
   output logic [W-1:0] sig_next
);

   always_comb begin
      sig_next = {sig[W-2:0], ^(sig & TAPS)} ^ resp_in;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/c880_bist_ctrl.sv
// BIST controller around the c880 netlist: LFSR patterns out, MISR-compacted responses in,
// signature compared to GOLDEN after PATTERNS absorptions.
module c880_bist_ctrl
   import c880_bist_pkg::*;
#(
   parameter int              PATTERNS = 1024,
   parameter logic [PI_W-1:0] SEED     = 60'h1,
   parameter logic [PO_W-1:0] GOLDEN   = 26'h0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [PI_W-1:0]                 pat_out,
   input  logic [PO_W-1:0]                 resp_in,
   output logic [PO_W-1:0]                 signature,
   output logic [$clog2(PATTERNS+1)-1:0]   count
);

   localparam int CW = $clog2(PATTERNS+1);
   localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

   if (SEED == '0) begin : g_bad_seed
      $error("c880_bist_ctrl: SEED must be non-zero");
   end

   bist_state_t     state;
   logic            launch;
   logic [PO_W-1:0] sig_next;

   assign busy   = (state == ST_RUN);
   assign launch = start && (state != ST_RUN);

   c880_misr #(
      .W    (PO_W),
      .TAPS (MISR_TAPS)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .en       (busy),
      .clr      (launch),
      .resp_in  (resp_in),
      .sig      (signature),
      .sig_next (sig_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pat_out <= '0;
         count   <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_RUN;
                  pat_out <= SEED;
                  count   <= '0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end
            end
            ST_RUN: begin
               pat_out <= {pat_out[PI_W-2:0], ^(pat_out & LFSR_TAPS)};
               count   <= count + CW'(1);
               // Final absorption: judge the signature being written on this same edge.
               if (count == LAST) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= (sig_next == GOLDEN);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_c880_bist_ctrl.sv
// Directed bench for c880_bist_ctrl: main DUT (PATTERNS=4, GOLDEN=0) plus a GOLDEN=9 twin
// and a single-pattern instance sharing clock, reset and start.
module tb_c880_bist_ctrl;
   import c880_bist_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic resp_mode = 1'b0;
   logic [PO_W-1:0] resp_const = '0;
   logic [PO_W-1:0] resp_main;

   logic            busy, done, pass;
   logic [PI_W-1:0] pat_out;
   logic [PO_W-1:0] signature;
   logic [2:0]      count;

   logic            busy9, done9, pass9;
   logic [PI_W-1:0] pat9;
   logic [PO_W-1:0] sig9;
   logic [2:0]      count9;

   logic            busy1, done1, pass1;
   logic [PI_W-1:0] pat1;
   logic [PO_W-1:0] sig1;
   logic [0:0]      count1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign resp_main = resp_mode ? pat_out[PO_W-1:0] : resp_const;

   c880_bist_ctrl #(.PATTERNS(4), .SEED(60'h1), .GOLDEN(26'h0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .pat_out(pat_out), .resp_in(resp_main), .signature(signature), .count(count)
   );

   c880_bist_ctrl #(.PATTERNS(4), .SEED(60'h1), .GOLDEN(26'h9)) u_dut9 (
      .clk(clk), .rst(rst), .start(start), .busy(busy9), .done(done9), .pass(pass9),
      .pat_out(pat9), .resp_in(resp_main), .signature(sig9), .count(count9)
   );

   c880_bist_ctrl #(.PATTERNS(1), .SEED(60'h1), .GOLDEN(26'h1)) u_one (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .pass(pass1),
      .pat_out(pat1), .resp_in(resp_const), .signature(sig1), .count(count1)
   );

   // Pulse start across one rising edge; returns at the negedge of busy cycle 1.
   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, pass} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {busy, done, pass});
      end
      checks++;
      if (pat_out !== '0 || signature !== '0 || count !== 3'd0) begin
         failures++;
         $display("FAIL reset_regs got pat=%0h sig=%0h cnt=%0d exp 0/0/0", pat_out, signature, count);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy got=%b exp=0", busy);
      end
   endtask

   // Walks four busy cycles checking pat_out, signature and count, then the DONE state.
   task automatic run_and_check(input string name, input logic [PO_W-1:0] exp_sig[5],
                                input logic exp_pass, input logic exp_pass9);
      logic [PI_W-1:0] exp_pat;
      exp_pat = 60'h1;
      do_start();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (busy !== 1'b1 || pat_out !== exp_pat || signature !== exp_sig[i] || count !== 3'(i)) begin
            failures++;
            $display("FAIL %s_cyc%0d got busy=%b pat=%0h sig=%0h cnt=%0d exp busy=1 pat=%0h sig=%0h cnt=%0d",
                     name, i + 1, busy, pat_out, signature, count, exp_pat, exp_sig[i], i);
         end
         exp_pat = exp_pat << 1;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || pass !== exp_pass || signature !== exp_sig[4] || count !== 3'd4) begin
         failures++;
         $display("FAIL %s_done got busy=%b done=%b pass=%b sig=%0h cnt=%0d exp busy=0 done=1 pass=%b sig=%0h cnt=4",
                  name, busy, done, pass, signature, count, exp_pass, exp_sig[4]);
      end
      checks++;
      if (pat_out !== 60'h10) begin
         failures++;
         $display("FAIL %s_pat_final got=%0h exp=10", name, pat_out);
      end
      checks++;
      if (done9 !== 1'b1 || pass9 !== exp_pass9) begin
         failures++;
         $display("FAIL %s_golden9 got done=%b pass=%b exp done=1 pass=%b", name, done9, pass9, exp_pass9);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b1 || pass !== exp_pass || signature !== exp_sig[4] || count !== 3'd4 || pat_out !== 60'h10) begin
         failures++;
         $display("FAIL %s_hold got done=%b pass=%b sig=%0h cnt=%0d pat=%0h", name, done, pass, signature, count, pat_out);
      end
   endtask

   task automatic test_zero_resp();
      logic [PO_W-1:0] s[5];
      s = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0};
      resp_mode = 1'b0;
      resp_const = 26'h0;
      run_and_check("zero_resp", s, 1'b1, 1'b0);
   endtask

   task automatic test_const_resp();
      logic [PO_W-1:0] s[5];
      s = '{26'h0, 26'h1, 26'h2, 26'h4, 26'h9};
      resp_mode = 1'b0;
      resp_const = 26'h1;
      run_and_check("const_resp", s, 1'b0, 1'b1);
      checks++;
      if (done1 !== 1'b1 || pass1 !== 1'b1 || sig1 !== 26'h1 || count1 !== 1'b1 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL one_pattern got done=%b pass=%b sig=%0h cnt=%0d busy=%b exp 1/1/1/1/0",
                  done1, pass1, sig1, count1, busy1);
      end
   endtask

   // Response follows the pattern's low bits, standing in for a combinational netlist.
   task automatic test_pat_resp();
      logic [PO_W-1:0] s[5];
      s = '{26'h0, 26'h1, 26'h1, 26'h7, 26'h6};
      resp_mode = 1'b1;
      run_and_check("pat_resp", s, 1'b0, 1'b0);
      resp_mode = 1'b0;
   endtask

   task automatic test_rst_abort();
      logic [PO_W-1:0] s[5];
      s = '{26'h0, 26'h1, 26'h2, 26'h4, 26'h9};
      resp_const = 26'h1;
      do_start();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, pass} !== 3'b000 || pat_out !== '0 || signature !== '0 || count !== 3'd0) begin
         failures++;
         $display("FAIL rst_abort got busy=%b done=%b pass=%b pat=%0h sig=%0h cnt=%0d exp all zero",
                  busy, done, pass, pat_out, signature, count);
      end
      run_and_check("after_abort", s, 1'b0, 1'b1);
   endtask

   task automatic test_start_in_run();
      resp_const = 26'h1;
      do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || count !== 3'd2 || signature !== 26'h2) begin
         failures++;
         $display("FAIL start_in_run_mid got busy=%b cnt=%0d sig=%0h exp busy=1 cnt=2 sig=2", busy, count, signature);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b1 || count !== 3'd4 || signature !== 26'h9 || pass9 !== 1'b1) begin
         failures++;
         $display("FAIL start_in_run_end got done=%b cnt=%0d sig=%0h pass9=%b exp 1/4/9/1", done, count, signature, pass9);
      end
   endtask

   task automatic test_restart_done();
      resp_const = 26'h1;
      do_start();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || count !== 3'd0 || signature !== 26'h0 || pat_out !== 60'h1) begin
         failures++;
         $display("FAIL restart got done=%b busy=%b cnt=%0d sig=%0h pat=%0h exp 0/1/0/0/1",
                  done, busy, count, signature, pat_out);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (done !== 1'b1 || signature !== 26'h9 || count !== 3'd4) begin
         failures++;
         $display("FAIL restart_end got done=%b sig=%0h cnt=%0d exp 1/9/4", done, signature, count);
      end
   endtask

   initial begin
      test_reset();
      test_zero_resp();
      test_const_resp();
      test_pat_resp();
      test_rst_abort();
      test_start_in_run();
      test_restart_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
